// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the off-chip 16-bit SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;

   localparam logic [31:0] DEFAULT_MEM_BASE = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// 4-bit loadable down-counter that times one SRAM half-access.
module sram_wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] value,
   output logic       zero
);

   logic [3:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= 4'd0;
      end else if (load) begin
         count_reg <= value;
      end else if (count_reg != 4'd0) begin
         count_reg <= count_reg - 4'd1;
      end
   end

   assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// Sequences each 32-bit MEM-stage load/store as two 16-bit SRAM half-accesses,
// holding ready low so the pipeline freezes until the access completes.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic        write_reg;
   logic [16:0] word_reg;
   logic [31:0] data_reg;
   logic [31:0] read_data_reg;
   logic        cnt_load;
   logic        cnt_zero;
   logic        request;
   logic [31:0] byte_offset;
   logic        unused_offset_bits;

   assign request     = wr_en | rd_en;
   assign byte_offset = address - MEM_BASE;
   // Byte-lane bits and word bits above the SRAM depth are dropped.
   assign unused_offset_bits = ^{byte_offset[31:19], byte_offset[1:0]};

   sram_wait_counter u_wait_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .value (WAIT_LOAD),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_load    = 1'b0;
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (state_reg)
         IDLE: begin
            ready = ~request;
            if (request) begin
               state_next = LOW;
               cnt_load   = 1'b1;
            end
         end
         LOW: begin
            sram_addr = {word_reg, 1'b0};
            if (write_reg) begin
               // Last cycle of the phase holds address/data with the strobe released.
               sram_dq_oe  = 1'b1;
               sram_dq_out = data_reg[15:0];
               sram_we_n   = cnt_zero;
            end
            if (cnt_zero) begin
               state_next = HIGH;
               cnt_load   = 1'b1;
            end
         end
         HIGH: begin
            sram_addr = {word_reg, 1'b1};
            if (write_reg) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = data_reg[31:16];
               sram_we_n   = cnt_zero;
            end
            if (cnt_zero) begin
               state_next = DONE;
            end
         end
         DONE: begin
            ready      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_reg     <= 1'b0;
         word_reg      <= '0;
         data_reg      <= '0;
         read_data_reg <= '0;
      end else begin
         if (state_reg == IDLE && request) begin
            write_reg <= wr_en;
            word_reg  <= byte_offset[18:2];
            data_reg  <= write_data;
         end
         if (state_reg == LOW && cnt_zero && !write_reg) begin
            read_data_reg[15:0] <= sram_dq_in;
         end
         if (state_reg == HIGH && cnt_zero && !write_reg) begin
            read_data_reg[31:16] <= sram_dq_in;
         end
      end
   end

   assign read_data = read_data_reg;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: W=2 instance on an SRAM model, plus a W=5
// instance on a fixed-pattern SRAM for the long-wait load.
module tb_sram_controller;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        wr_en_5, rd_en_5;
   logic [31:0] address_5, write_data_5, read_data_5;
   logic        ready_5;
   logic [17:0] sram_addr_5;
   logic [15:0] sram_dq_out_5, sram_dq_in_5;
   logic        sram_dq_oe_5, sram_we_n_5;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] model_word[logic [31:0]];
   logic [31:0] last_rd = 32'd0;
   logic [15:0] sram_mem [0:255];

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   sram_controller #(.WAIT_CYCLES(5)) u_dut_5 (
      .clk(clk), .rst(rst), .wr_en(wr_en_5), .rd_en(rd_en_5),
      .address(address_5), .write_data(write_data_5), .read_data(read_data_5),
      .ready(ready_5), .sram_addr(sram_addr_5), .sram_dq_out(sram_dq_out_5),
      .sram_dq_in(sram_dq_in_5), .sram_dq_oe(sram_dq_oe_5), .sram_we_n(sram_we_n_5)
   );

   // Asynchronous SRAM model: write while strobe is low, combinational read.
   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[7:0]] <= sram_dq_out;
   end
   assign sram_dq_in   = sram_mem[sram_addr[7:0]];
   assign sram_dq_in_5 = sram_addr_5[0] ? 16'hABCD : 16'h1234;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic move_addr, input string tag);
      int          frozen;
      int          we_lows;
      logic [31:0] off;
      logic [16:0] w;
      logic [17:0] first_a, last_a;
      logic [15:0] first_d, last_d;
      logic [31:0] exp;
      off = (addr - 32'd1024) >> 2;
      w = off[16:0];
      first_a = '0; last_a = '0; first_d = '0; last_d = '0;
      @(negedge clk);
      wr_en = wr; rd_en = rd; address = addr; write_data = data;
      if (wr) model_word[addr] = data;
      else exp_q.push_back(model_word.exists(addr) ? model_word[addr] : 32'd0);
      #1;
      check($sformatf("%s.ready_c0", tag), 32'(ready), 32'd0);
      frozen = 0;
      we_lows = 0;
      while (ready !== 1'b1 && frozen < 50) begin
         if (frozen >= 1)
            check($sformatf("%s.addr_c%0d", tag, frozen), 32'(sram_addr),
                  32'({w, (frozen > W) ? 1'b1 : 1'b0}));
         if (sram_we_n === 1'b0) begin
            if (we_lows == 0) begin first_a = sram_addr; first_d = sram_dq_out; end
            last_a = sram_addr;
            last_d = sram_dq_out;
            we_lows++;
         end
         frozen++;
         @(negedge clk);
         #1;
         if (move_addr && frozen == 1) begin
            address    = addr + 32'd64;
            write_data = ~data;
         end
      end
      check($sformatf("%s.frozen", tag), 32'(frozen), 32'(2 * W + 1));
      if (wr) begin
         check($sformatf("%s.we_lows", tag), 32'(we_lows), 32'(2 * (W - 1)));
         check($sformatf("%s.lo_addr", tag), 32'(first_a), 32'({w, 1'b0}));
         check($sformatf("%s.lo_data", tag), 32'(first_d), 32'(data[15:0]));
         check($sformatf("%s.hi_addr", tag), 32'(last_a), 32'({w, 1'b1}));
         check($sformatf("%s.hi_data", tag), 32'(last_d), 32'(data[31:16]));
         check($sformatf("%s.rd_kept", tag), read_data, last_rd);
      end else begin
         exp = exp_q.pop_front();
         last_rd = exp;
         check($sformatf("%s.read_data", tag), read_data, exp);
      end
      $display("%s: wr=%0b rd=%0b addr=%0d frozen=%0d read_data=%h", tag, wr, rd, addr, frozen, read_data);
   endtask

   task automatic go_idle();
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #1;
      check("idle.ready", 32'(ready), 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      wr_en = 0; rd_en = 0; address = 0; write_data = 0;
      wr_en_5 = 0; rd_en_5 = 0; address_5 = 0; write_data_5 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst.ready", 32'(ready), 32'd1);
      check("rst.we_n", 32'(sram_we_n), 32'd1);
      check("rst.oe", 32'(sram_dq_oe), 32'd0);
      check("rst.addr", 32'(sram_addr), 32'd0);
      check("rst.read_data", read_data, 32'd0);
      check("rst.ready_5", 32'(ready_5), 32'd1);
      rst = 1'b0;

      access(1, 0, 32'd1028, 32'hDEADBEEF, 0, "st1028");
      go_idle();
      access(0, 1, 32'd1028, 32'h0, 0, "ld1028");
      go_idle();

      access(1, 0, 32'd1024, 32'hCAFEF00D, 0, "b2b_st");
      access(0, 1, 32'd1024, 32'h0, 0, "b2b_ld");
      go_idle();

      access(1, 1, 32'd1036, 32'h0BADF00D, 0, "both");
      go_idle();
      access(0, 1, 32'd1036, 32'h0, 0, "ld1036");
      go_idle();

      access(0, 1, 32'd1028, 32'h0, 1, "ld_move");
      go_idle();
      access(1, 0, 32'd1044, 32'h12345678, 1, "st_move");
      go_idle();
      access(0, 1, 32'd1044, 32'h0, 0, "ld1044");
      go_idle();

      // Reset in the first HIGH-phase cycle of a write to 1040 (word 4).
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h55AA55AA;
      repeat (3) @(negedge clk);
      #1;
      check("rstmid.in_high", 32'(sram_addr), 32'd9);
      rst = 1'b1;
      wr_en = 1'b0;
      @(negedge clk);
      #1;
      check("rstmid.we_n", 32'(sram_we_n), 32'd1);
      check("rstmid.oe", 32'(sram_dq_oe), 32'd0);
      check("rstmid.read_data", read_data, 32'd0);
      check("rstmid.ready", 32'(ready), 32'd1);
      check("rstmid.addr", 32'(sram_addr), 32'd0);
      $display("rstmid: we_n=%0b oe=%0b ready=%0b read_data=%h", sram_we_n, sram_dq_oe, ready, read_data);
      last_rd = 32'd0;
      rst = 1'b0;
      access(0, 1, 32'd1028, 32'h0, 0, "ld_after_rst");
      go_idle();

      @(negedge clk);
      rd_en_5 = 1'b1;
      address_5 = 32'd1032;
      #1;
      n = 0;
      while (ready_5 !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("w5.frozen", 32'(n), 32'd11);
      check("w5.read_data", read_data_5, 32'hABCD1234);
      $display("w5_ld1032: frozen=%0d read_data=%h", n, read_data_5);
      rd_en_5 = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
